// File: rtl/output_port_arbiter.sv
// Round-robin arbiter sharing one router output port among N_IN two-phase
// (toggle) req/ack input channels; completes the input handshake after out_ack.
module output_port_arbiter #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned WIDTH       = 34,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          in_req,
  input  logic [N_IN*WIDTH-1:0]    in_data,
  output logic [N_IN-1:0]          in_ack,
  output logic                     out_req,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ack,
  output logic [$clog2(N_IN)-1:0]  grant_idx,
  output logic                     busy
);

  localparam int unsigned IdxW = $clog2(N_IN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_IN - 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e                 state_q, state_d;
  logic [N_IN-1:0]        req_sync_q [SYNC_STAGES];
  logic [N_IN-1:0]        req_sync_d [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [N_IN-1:0]        in_ack_q, in_ack_d;
  logic                   out_req_q, out_req_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic [IdxW-1:0]        grant_q, grant_d;
  logic                   busy_q, busy_d;

  logic [N_IN-1:0]        req_s;
  logic                   ack_s;
  logic [N_IN-1:0]        pend;
  logic                   win_found;
  logic [IdxW-1:0]        win_idx;
  logic [IdxW-1:0]        cand;
  logic [WIDTH-1:0]       win_data;

  always_comb begin
    req_sync_d[0] = in_req;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      req_sync_d[s] = req_sync_q[s-1];
    end
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], out_ack};
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign pend  = req_s ^ in_ack_q;

  // Search starts one past the last grant; wrap is an explicit compare so
  // non-power-of-two N_IN works.
  always_comb begin
    win_found = 1'b0;
    win_idx   = grant_q;
    cand      = grant_q;
    for (int k = 0; k < N_IN; k++) begin
      cand = (cand == LastIdx) ? '0 : cand + IdxW'(1);
      if (!win_found && pend[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_data = in_data[win_idx*WIDTH +: WIDTH];

  always_comb begin
    state_d    = state_q;
    in_ack_d   = in_ack_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          out_data_d = win_data;
          out_req_d  = ~out_req_q;
          grant_d    = win_idx;
          busy_d     = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        // Level compare: the downstream ack matches our request phase.
        if (ack_s == out_req_q) begin
          in_ack_d[grant_q] = ~in_ack_q[grant_q];
          busy_d            = 1'b0;
          state_d           = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        req_sync_q[s] <= '0;
      end
      ack_sync_q <= '0;
      state_q    <= StIdle;
      in_ack_q   <= '0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      grant_q    <= LastIdx;
      busy_q     <= 1'b0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        req_sync_q[s] <= req_sync_d[s];
      end
      ack_sync_q <= ack_sync_d;
      state_q    <= state_d;
      in_ack_q   <= in_ack_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ack    = in_ack_q;
  assign out_req   = out_req_q;
  assign out_data  = out_data_q;
  assign grant_idx = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: a 4-input instance for the main
// scenarios and a 3-input instance for non-power-of-two pointer wrap.
module tb_output_port_arbiter;

  localparam int unsigned W = 34;

  logic clk;
  logic rst;

  logic [3:0]     in_req;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ack;
  logic           out_req;
  logic [W-1:0]   out_data;
  logic           out_ack;
  logic [1:0]     grant_idx;
  logic           busy;

  logic [2:0]     in_req3;
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_ack3;
  logic           out_req3;
  logic [W-1:0]   out_data3;
  logic           out_ack3;
  logic [1:0]     grant_idx3;
  logic           busy3;

  int checks = 0;
  int errors = 0;

  logic       exp_oreq4, exp_oreq3;
  logic [7:0] exp_ack4, exp_ack3;

  output_port_arbiter #(.N_IN(4), .WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .grant_idx(grant_idx), .busy(busy)
  );

  output_port_arbiter #(.N_IN(3), .WIDTH(W), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst(rst), .in_req(in_req3), .in_data(in_data3), .in_ack(in_ack3),
    .out_req(out_req3), .out_data(out_data3), .out_ack(out_ack3),
    .grant_idx(grant_idx3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit d3, output logic oreq, output logic [W-1:0] odata,
                        output logic [1:0] gidx, output logic [7:0] iack, output logic b);
    if (d3) begin
      oreq = out_req3; odata = out_data3; gidx = grant_idx3; iack = {5'b0, in_ack3}; b = busy3;
    end else begin
      oreq = out_req; odata = out_data; gidx = grant_idx; iack = {4'b0, in_ack}; b = busy;
    end
  endtask

  // A requester may only toggle once its previous request has been acked.
  task automatic toggle_req(input bit d3, input int i, input logic [W-1:0] data);
    if (d3) begin
      check($sformatf("proto3_%0d", i), {63'b0, in_req3[i]}, {63'b0, in_ack3[i]});
      in_data3[i*W +: W] = data;
      in_req3[i] = ~in_req3[i];
    end else begin
      check($sformatf("proto_%0d", i), {63'b0, in_req[i]}, {63'b0, in_ack[i]});
      in_data[i*W +: W] = data;
      in_req[i] = ~in_req[i];
    end
  endtask

  task automatic grant_wait(input bit d3, input int idx, input logic [W-1:0] data);
    logic oreq, b;
    logic [W-1:0] od;
    logic [1:0] g;
    logic [7:0] ia;
    logic eo;
    int n;
    eo = d3 ? exp_oreq3 : exp_oreq4;
    n = 0;
    sample(d3, oreq, od, g, ia, b);
    while (oreq === eo && n < 20) begin
      tick();
      n++;
      sample(d3, oreq, od, g, ia, b);
    end
    eo = ~eo;
    if (d3) exp_oreq3 = eo; else exp_oreq4 = eo;
    check($sformatf("oreq_g%0d", idx), {63'b0, oreq}, {63'b0, eo});
    check($sformatf("grant_g%0d", idx), {62'b0, g}, 64'(idx));
    check($sformatf("data_g%0d", idx), {30'b0, od}, {30'b0, data});
    check($sformatf("busy_g%0d", idx), {63'b0, b}, 64'd1);
  endtask

  task automatic ack_done(input bit d3, input int idx);
    logic oreq, b;
    logic [W-1:0] od;
    logic [1:0] g;
    logic [7:0] ia;
    if (d3) begin
      out_ack3 = exp_oreq3;
      exp_ack3[idx] = ~exp_ack3[idx];
    end else begin
      out_ack = exp_oreq4;
      exp_ack4[idx] = ~exp_ack4[idx];
    end
    tick(); tick(); tick();
    sample(d3, oreq, od, g, ia, b);
    check($sformatf("inack_a%0d", idx), {56'b0, ia}, {56'b0, d3 ? exp_ack3 : exp_ack4});
    check($sformatf("busy_a%0d", idx), {63'b0, b}, 64'd0);
  endtask

  task automatic serve(input bit d3, input int idx, input logic [W-1:0] data);
    grant_wait(d3, idx, data);
    ack_done(d3, idx);
  endtask

  initial begin
    rst = 1'b0;
    in_req = '0; in_data = '0; out_ack = 1'b0;
    in_req3 = '0; in_data3 = '0; out_ack3 = 1'b0;
    exp_oreq4 = 1'b0; exp_oreq3 = 1'b0; exp_ack4 = '0; exp_ack3 = '0;

    #12;
    check("rst_oreq", {63'b0, out_req}, 64'd0);
    check("rst_data", {30'b0, out_data}, 64'd0);
    check("rst_grant", {62'b0, grant_idx}, 64'd3);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_inack", {60'b0, in_ack}, 64'd0);
    check("rst_grant3", {62'b0, grant_idx3}, 64'd2);
    tick();
    rst = 1'b1;
    tick();

    // T1: single request, exact latencies.
    toggle_req(0, 0, 34'h0_FFFFFFFF);
    tick(); tick();
    check("t1_oreq_early", {63'b0, out_req}, 64'd0);
    tick();
    check("t1_oreq", {63'b0, out_req}, 64'd1);
    check("t1_data", {30'b0, out_data}, 64'h0_FFFFFFFF);
    check("t1_grant", {62'b0, grant_idx}, 64'd0);
    check("t1_busy", {63'b0, busy}, 64'd1);
    exp_oreq4 = 1'b1;
    repeat (10) tick();
    check("t1_inack_hold", {60'b0, in_ack}, 64'd0);
    out_ack = 1'b1;
    tick(); tick();
    check("t1_inack_early", {60'b0, in_ack}, 64'd0);
    tick();
    check("t1_inack", {60'b0, in_ack}, 64'd1);
    check("t1_busy_end", {63'b0, busy}, 64'd0);
    exp_ack4[0] = 1'b1;

    // T2: all four at once, rotation from input 1 (pointer sits at 0).
    for (int i = 0; i < 4; i++) toggle_req(0, i, 34'(8'hA0 + i));
    serve(0, 1, 34'hA1);
    serve(0, 2, 34'hA2);
    serve(0, 3, 34'hA3);
    serve(0, 0, 34'hA0);

    // T3: input 1 re-toggles after each ack, input 2 stays pending.
    toggle_req(0, 1, 34'hB1);
    toggle_req(0, 2, 34'hB2);
    serve(0, 1, 34'hB1);
    toggle_req(0, 1, 34'hC1);
    serve(0, 2, 34'hB2);
    toggle_req(0, 2, 34'hC2);
    serve(0, 1, 34'hC1);
    serve(0, 2, 34'hC2);

    // T4: slow sink with inputs 0 and 3 pending; pointer at 2 so 3 wins.
    toggle_req(0, 0, 34'hD0);
    toggle_req(0, 3, 34'hD3);
    grant_wait(0, 3, 34'hD3);
    for (int c = 0; c < 50; c++) begin
      tick();
      check("t4_busy", {63'b0, busy}, 64'd1);
      check("t4_oreq", {63'b0, out_req}, {63'b0, exp_oreq4});
      check("t4_data", {30'b0, out_data}, 64'hD3);
      check("t4_inack", {60'b0, in_ack}, {56'b0, exp_ack4});
    end
    ack_done(0, 3);
    serve(0, 0, 34'hD0);

    // T5: asynchronous reset while a transfer is outstanding.
    toggle_req(0, 1, 34'hE1);
    grant_wait(0, 1, 34'hE1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_oreq", {63'b0, out_req}, 64'd0);
    check("t5_data", {30'b0, out_data}, 64'd0);
    check("t5_grant", {62'b0, grant_idx}, 64'd3);
    check("t5_busy", {63'b0, busy}, 64'd0);
    check("t5_inack", {60'b0, in_ack}, 64'd0);
    in_req = '0; in_data = '0; out_ack = 1'b0;
    exp_oreq4 = 1'b0; exp_ack4 = '0;
    tick();
    rst = 1'b1;
    tick();
    toggle_req(0, 2, 34'hF2);
    toggle_req(0, 0, 34'hF0);
    serve(0, 0, 34'hF0);
    serve(0, 2, 34'hF2);

    // T6: 3-input build, pointer wraps from 2 to 0.
    toggle_req(1, 2, 34'h2A);
    serve(1, 2, 34'h2A);
    toggle_req(1, 2, 34'h22);
    toggle_req(1, 0, 34'h20);
    serve(1, 0, 34'h20);
    serve(1, 2, 34'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
